// File: rtl/bf16_to_fp8_encoder_if.sv
// Stream interface for the BF16 -> FP8 encoder: one input lane, one output lane.
// master = producer/consumer side, slave = encoder side.
interface bf16_to_fp8_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bf16;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_fp8;

   modport master (output in_valid, in_bf16, out_ready,
                   input  in_ready, out_valid, out_fp8);
   modport slave  (input  in_valid, in_bf16, out_ready,
                   output in_ready, out_valid, out_fp8);
endinterface

// File: rtl/bf16_to_fp8_encoder.sv
// BF16 -> FP8 E4M3 (bias 7) encoder for activation/weight write-back.
// S1 classifies, aligns and decides the round increment (and the event flags
// that depend on it); S2 applies the increment and packs the final byte.
// Exp field 4'hF is used as inf; NaN inputs also encode as inf.
module bf16_to_fp8_encoder #(
   parameter bit FTZ_FP8  = 1'b1,
   parameter bit SATURATE = 1'b0,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   bf16_to_fp8_encoder_if.slave bus,
   input  logic                 clear_cnt,
   output logic [CNT_W-1:0]     overflow_cnt,
   output logic [CNT_W-1:0]     underflow_cnt
);
   // Operand classes carried from S1 to S2
   localparam logic [1:0] K_FIN  = 2'd0;  // finite, normal or subnormal result
   localparam logic [1:0] K_ZERO = 2'd1;  // BF16 zero / subnormal input
   localparam logic [1:0] K_INF  = 2'd2;  // BF16 inf / NaN input
   localparam logic [1:0] K_OVF  = 2'd3;  // finite, exponent already out of range

   logic              w_fire, w_s2_adv;
   logic              r_s1_valid, r_s2_valid;

   // S1 combinational
   logic              w_sign;
   logic [7:0]        w_e;
   logic [6:0]        w_m;
   logic signed [9:0] w_e8;
   logic [3:0]        w_sh;
   logic [16:0]       w_shf;
   logic [1:0]        w_kind;
   logic [3:0]        w_exp;
   logic [2:0]        w_man;
   logic              w_g, w_st, w_up;
   logic [6:0]        w_sum;
   logic              w_ovf, w_unf;

   // S1 registers
   logic              r_s1_sign, r_s1_up, r_s1_ovf, r_s1_unf;
   logic [1:0]        r_s1_kind;
   logic [3:0]        r_s1_exp;
   logic [2:0]        r_s1_man;

   // S2
   logic [6:0]        w_rsum;
   logic [7:0]        w_pack, w_ovf_pat;
   logic [7:0]        r_out;

   assign w_s2_adv     = r_s1_valid & (~r_s2_valid | bus.out_ready);
   assign bus.in_ready = ~r_s1_valid | w_s2_adv;
   assign w_fire       = bus.in_valid & bus.in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.out_fp8   = r_out;

   assign w_sign = bus.in_bf16[15];
   assign w_e    = bus.in_bf16[14:7];
   assign w_m    = bus.in_bf16[6:0];
   // FP8 exponent before rounding: rebias 127 -> 7
   assign w_e8   = $signed({2'b00, w_e}) - 10'sd120;
   // Subnormal alignment; beyond 10 every significand bit lands in sticky anyway
   assign w_sh   = (w_e8 < -10'sd8) ? 4'd10 : 4'(10'sd1 - w_e8);
   // Bits [16:14] = kept fraction, [13] = guard, [12:0] = sticky
   assign w_shf  = 17'({1'b1, w_m, 10'b0} >> w_sh);

   // S1: classify, align, round-nearest-even decision and event flags
   always_comb begin
      w_kind = K_FIN;
      w_exp  = 4'h0;
      w_man  = 3'h0;
      w_g    = 1'b0;
      w_st   = 1'b0;
      if (w_e == 8'h00)
         w_kind = K_ZERO;
      else if (w_e == 8'hFF)
         w_kind = K_INF;
      else if (w_e8 >= 10'sd15)
         w_kind = K_OVF;
      else if (w_e8 >= 10'sd1) begin
         w_exp = w_e8[3:0];
         w_man = w_m[6:4];
         w_g   = w_m[3];
         w_st  = |w_m[2:0];
      end else begin
         w_man = w_shf[16:14];
         w_g   = w_shf[13];
         w_st  = |w_shf[12:0];
      end
      w_up  = w_g & (w_st | w_man[0]);
      // Mantissa carry ripples into the exponent field for free
      w_sum = {w_exp, w_man} + {6'd0, w_up};
      w_ovf = (w_kind == K_OVF) | ((w_kind == K_FIN) && (w_sum[6:3] == 4'hF));
      w_unf = ((w_kind == K_ZERO) && (w_m != 7'h0)) |
              ((w_kind == K_FIN) && ((w_sum == 7'h0) || (FTZ_FP8 && (w_sum[6:3] == 4'h0))));
   end

   // S1 register: load on accept, valid drops when the item moves to S2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_kind  <= K_ZERO;
         r_s1_exp   <= 4'h0;
         r_s1_man   <= 3'h0;
         r_s1_up    <= 1'b0;
         r_s1_ovf   <= 1'b0;
         r_s1_unf   <= 1'b0;
      end else begin
         if (w_fire)
            r_s1_valid <= 1'b1;
         else if (w_s2_adv)
            r_s1_valid <= 1'b0;
         if (w_fire) begin
            r_s1_sign <= w_sign;
            r_s1_kind <= w_kind;
            r_s1_exp  <= w_exp;
            r_s1_man  <= w_man;
            r_s1_up   <= w_up;
            r_s1_ovf  <= w_ovf;
            r_s1_unf  <= w_unf;
         end
      end
   end

   assign w_rsum    = {r_s1_exp, r_s1_man} + {6'd0, r_s1_up};
   assign w_ovf_pat = SATURATE ? {r_s1_sign, 7'h77} : {r_s1_sign, 7'h78};

   // S2: apply rounding, overflow/flush handling, pack
   always_comb begin
      w_pack = {r_s1_sign, w_rsum};
      case (r_s1_kind)
         K_ZERO:  w_pack = {r_s1_sign, 7'h00};
         K_INF:   w_pack = {r_s1_sign, 7'h78};
         K_OVF:   w_pack = w_ovf_pat;
         default: begin
            if (w_rsum[6:3] == 4'hF)
               w_pack = w_ovf_pat;
            else if (FTZ_FP8 && (w_rsum[6:3] == 4'h0))
               w_pack = {r_s1_sign, 7'h00};
         end
      endcase
   end

   // S2 / output register: held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_out      <= 8'h00;
      end else begin
         if (w_s2_adv) begin
            r_s2_valid <= 1'b1;
            r_out      <= w_pack;
         end else if (bus.out_ready)
            r_s2_valid <= 1'b0;
      end
   end

   // Event counters: one count per item as it enters S2, saturating, clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_cnt  <= '0;
         underflow_cnt <= '0;
      end else if (clear_cnt) begin
         overflow_cnt  <= '0;
         underflow_cnt <= '0;
      end else if (w_s2_adv) begin
         if (r_s1_ovf && !(&overflow_cnt))
            overflow_cnt <= overflow_cnt + CNT_W'(1);
         if (r_s1_unf && !(&underflow_cnt))
            underflow_cnt <= underflow_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_bf16_to_fp8_encoder.sv
// Scoreboard bench: two encoders (FTZ=0/SAT=0/16-bit counters and
// FTZ=1/SAT=1/2-bit counters) share one stimulus stream; expected bytes are
// queued at accept time and popped by per-DUT monitors on each transfer.
module tb_bf16_to_fp8_encoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   bf16_to_fp8_encoder_if ifc0 ();
   bf16_to_fp8_encoder_if ifc1 ();
   assign ifc1.in_valid  = ifc0.in_valid;
   assign ifc1.in_bf16   = ifc0.in_bf16;
   assign ifc1.out_ready = ifc0.out_ready;

   logic [15:0] ovf0, unf0;
   logic [1:0]  ovf1, unf1;

   bf16_to_fp8_encoder #(.FTZ_FP8(1'b0), .SATURATE(1'b0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .bus(ifc0), .clear_cnt(clr),
      .overflow_cnt(ovf0), .underflow_cnt(unf0));
   bf16_to_fp8_encoder #(.FTZ_FP8(1'b1), .SATURATE(1'b1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(ifc1), .clear_cnt(clr),
      .overflow_cnt(ovf1), .underflow_cnt(unf1));

   typedef struct {logic [7:0] d; int acc; bit lat;} exp_t;
   // f = {ovf0, unf0, ovf1, unf1} expected event flags
   typedef struct {logic [15:0] d; logic [7:0] e0; logic [7:0] e1; logic [3:0] f;} vec_t;

   exp_t q0[$], q1[$];
   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int m_ovf0 = 0, m_unf0 = 0, m_ovf1 = 0, m_unf1 = 0;

   vec_t vt [23] = '{
      '{16'h3F80, 8'h38, 8'h38, 4'b0000},  // 1.0
      '{16'hBFD0, 8'hBD, 8'hBD, 4'b0000},  // -1.625
      '{16'h3F88, 8'h38, 8'h38, 4'b0000},  // tie, round to even (down)
      '{16'h3F98, 8'h3A, 8'h3A, 4'b0000},  // tie, round to even (up)
      '{16'h3F90, 8'h39, 8'h39, 4'b0000},  // exact
      '{16'h4370, 8'h77, 8'h77, 4'b0000},  // 240 = max finite
      '{16'h4378, 8'h78, 8'h77, 4'b1010},  // 248 rounds over
      '{16'h4380, 8'h78, 8'h77, 4'b1010},  // 256
      '{16'h7F80, 8'h78, 8'h78, 4'b0000},  // +inf
      '{16'h7FC0, 8'h78, 8'h78, 4'b0000},  // NaN
      '{16'hFF80, 8'hF8, 8'hF8, 4'b0000},  // -inf
      '{16'h3C00, 8'h04, 8'h00, 4'b0001},  // 2^-7 subnormal
      '{16'h3A80, 8'h00, 8'h00, 4'b0101},  // 2^-10 tie to zero
      '{16'h3A90, 8'h01, 8'h00, 4'b0001},  // just above the tie
      '{16'h0001, 8'h00, 8'h00, 4'b0101},  // BF16 subnormal
      '{16'h8000, 8'h80, 8'h80, 4'b0000},  // -0
      '{16'h8001, 8'h80, 8'h80, 4'b0101},  // -BF16 subnormal
      '{16'hBC00, 8'h84, 8'h80, 4'b0001},  // -2^-7
      '{16'h3C70, 8'h08, 8'h08, 4'b0000},  // subnormal rounds up to min normal
      '{16'h3C80, 8'h08, 8'h08, 4'b0000},  // min normal 2^-6
      '{16'h8080, 8'h80, 8'h80, 4'b0101},  // far below range, shift clamp
      '{16'h7F7F, 8'h78, 8'h77, 4'b1010},  // max BF16 finite
      '{16'hC378, 8'hF8, 8'hF7, 4'b1010}   // -248
   };

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int sat_inc(input int v, input int mx);
      return (v < mx) ? v + 1 : mx;
   endfunction

   // Monitor, DUT0
   logic [7:0] hold0;
   bit         held0 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) held0 = 1'b0;
      else begin
         if (held0) begin
            check("stall_valid0", ifc0.out_valid, 1);
            check("stall_hold0", ifc0.out_fp8, hold0);
         end
         held0 = ifc0.out_valid & ~ifc0.out_ready;
         hold0 = ifc0.out_fp8;
         if (ifc0.out_valid && ifc0.out_ready) begin
            if (q0.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_out0: got 0x%0h, expected no output", ifc0.out_fp8);
            end else begin
               e = q0.pop_front();
               check("out_fp8_dut0", ifc0.out_fp8, e.d);
               if (e.lat) check("latency_dut0", cyc - e.acc, 2);
            end
         end
      end
   end

   // Monitor, DUT1
   logic [7:0] hold1;
   bit         held1 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) held1 = 1'b0;
      else begin
         if (held1) begin
            check("stall_valid1", ifc1.out_valid, 1);
            check("stall_hold1", ifc1.out_fp8, hold1);
         end
         held1 = ifc1.out_valid & ~ifc1.out_ready;
         hold1 = ifc1.out_fp8;
         if (ifc1.out_valid && ifc1.out_ready) begin
            if (q1.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_out1: got 0x%0h, expected no output", ifc1.out_fp8);
            end else begin
               e = q1.pop_front();
               check("out_fp8_dut1", ifc1.out_fp8, e.d);
               if (e.lat) check("latency_dut1", cyc - e.acc, 2);
            end
         end
      end
   end

   // Present one item, wait (bounded) for acceptance, queue expectations
   task automatic send(input vec_t v, input bit lat, input bit clr_after);
      int   t = 0;
      exp_t e;
      ifc0.in_valid = 1'b1;
      ifc0.in_bf16  = v.d;
      @(negedge clk);
      while (!ifc0.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!ifc0.in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL accept_timeout: in_ready 0 for %0d cycles, expected 1", t);
      end else begin
         e.d = v.e0; e.acc = cyc; e.lat = lat; q0.push_back(e);
         e.d = v.e1; q1.push_back(e);
         if (clr_after) begin
            m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
         end else begin
            if (v.f[3]) m_ovf0 = sat_inc(m_ovf0, 65535);
            if (v.f[2]) m_unf0 = sat_inc(m_unf0, 65535);
            if (v.f[1]) m_ovf1 = sat_inc(m_ovf1, 3);
            if (v.f[0]) m_unf1 = sat_inc(m_unf1, 3);
         end
      end
      @(posedge clk);
      #1 ifc0.in_valid = 1'b0;
      if (clr_after) begin
         // Item is in S1 now and moves to S2 on the next edge
         clr = 1'b1;
         @(posedge clk);
         #1 clr = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: %0d/%0d outstanding, expected 0", q0.size(), q1.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_ovf0"}, ovf0, m_ovf0);
      check({tag, "_unf0"}, unf0, m_unf0);
      check({tag, "_ovf1"}, ovf1, m_ovf1);
      check({tag, "_unf1"}, unf1, m_unf1);
   endtask

   initial begin
      vec_t v;
      ifc0.in_valid  = 1'b0;
      ifc0.in_bf16   = 16'h0;
      ifc0.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid0", ifc0.out_valid, 0);
      check("rst_out_valid1", ifc1.out_valid, 0);
      check("rst_out_fp8", ifc0.out_fp8, 8'h00);
      check("rst_in_ready", ifc0.in_ready, 1);
      check_cnts("rst");
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed vectors, full rate, consumer always ready
      foreach (vt[i]) send(vt[i], 1'b1, 1'b0);
      drain();
      check_cnts("vec");

      // Clear coincident with an overflow count
      v = '{16'h4378, 8'h78, 8'h77, 4'b1010};
      send(v, 1'b0, 1'b1);
      drain();
      check_cnts("clr");

      // Backpressure: consumer stalls, two items fill the pipe
      ifc0.out_ready = 1'b0;
      send('{16'h4378, 8'h78, 8'h77, 4'b1010}, 1'b0, 1'b0);
      send('{16'h3A80, 8'h00, 8'h00, 4'b0101}, 1'b0, 1'b0);
      @(negedge clk);
      check("bp_in_ready", ifc0.in_ready, 0);
      fork
         begin
            send('{16'h3F98, 8'h3A, 8'h3A, 4'b0000}, 1'b0, 1'b0);
            send('{16'h4380, 8'h78, 8'h77, 4'b1010}, 1'b0, 1'b0);
            send('{16'h3C00, 8'h04, 8'h00, 4'b0001}, 1'b0, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1 ifc0.out_ready = 1'b1;
         end
      join
      drain();
      check_cnts("bp");

      // Reset mid-stream with outputs pending
      ifc0.out_ready = 1'b0;
      send('{16'h4380, 8'h78, 8'h77, 4'b1010}, 1'b0, 1'b0);
      send('{16'h3F80, 8'h38, 8'h38, 4'b0000}, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid0", ifc0.out_valid, 0);
      check("mid_rst_out_valid1", ifc1.out_valid, 0);
      q0.delete();
      q1.delete();
      m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
      check_cnts("mid_rst");
      @(negedge clk);
      #1 rst = 1'b0;
      ifc0.out_ready = 1'b1;
      @(posedge clk);
      #1;
      send('{16'h3F80, 8'h38, 8'h38, 4'b0000}, 1'b1, 1'b0);
      drain();
      check_cnts("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
